// File: rtl/exp_normalize_2_if.sv
// Handshake and data bundle for the two-lane exponent normaliser.
// master: the producer/consumer side; slave: the normaliser itself.
interface exp_normalize_2_if #(
    parameter int unsigned expWidth = 4,
    parameter int unsigned sigWidth = 10
);
    localparam int unsigned SumWidth  = sigWidth + 3;
    localparam int unsigned LaneWidth = 1 + expWidth + sigWidth;

    logic                     in_valid;
    logic                     in_ready;
    logic [2*SumWidth-1:0]    in_sum;
    logic [expWidth-1:0]      max_exp;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*LaneWidth-1:0]   out_data;
    logic [1:0]               out_ovf;
    logic [1:0]               out_unf;

    modport master (
        output in_valid, in_sum, max_exp, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_sum, max_exp, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_unf
    );
endinterface

// File: rtl/exp_normalize_2.sv
// Two-lane post-addition normaliser: takes two aligned two's-complement sums sharing one
// exponent and produces {sign, exp, frac} per lane through a 3-stage valid/ready pipeline
// (magnitude, leading-one detect, shift + exponent adjust).
module exp_normalize_2 #(
    parameter int unsigned expWidth = 4,
    parameter int unsigned sigWidth = 10
) (
    input  logic clk,
    input  logic rstn,
    exp_normalize_2_if.slave bus
);
    localparam int unsigned SumWidth  = sigWidth + 3;
    localparam int unsigned MagWidth  = sigWidth + 2;
    localparam int unsigned PosWidth  = $clog2(MagWidth);
    localparam int unsigned LaneWidth = 1 + expWidth + sigWidth;
    // Signed exponent math wide enough for max_exp + 1 and 0 - sigWidth.
    localparam int unsigned ExpCalcWidth = ((expWidth > PosWidth) ? expWidth : PosWidth) + 2;
    localparam logic signed [ExpCalcWidth-1:0] ExpMax  = ExpCalcWidth'((1 << expWidth) - 1);
    localparam logic signed [ExpCalcWidth-1:0] ExpZero = '0;

    // Stage enables: a stage loads when empty or when it drains forward this cycle.
    logic s1_valid, s2_valid, s3_valid;
    logic s1_en, s2_en, s3_en;

    assign s3_en = !s3_valid || bus.out_ready;
    assign s2_en = !s2_valid || s3_en;
    assign s1_en = !s1_valid || s2_en;

    // Stage 1: sign and saturated magnitude.
    logic [1:0]                s1_sign, s1_sign_d;
    logic [1:0][MagWidth-1:0]  s1_mag, s1_mag_d;
    logic [expWidth-1:0]       s1_exp;
    logic [1:0][SumWidth-1:0]  lane_sum, lane_neg;

    // Stage 2: leading-one position and zero flag.
    logic [1:0]                s2_sign;
    logic [1:0][MagWidth-1:0]  s2_mag;
    logic [1:0][PosWidth-1:0]  s2_pos, s2_pos_d;
    logic [1:0]                s2_zero, s2_zero_d;
    logic [expWidth-1:0]       s2_exp;

    // Stage 3: packed result and flags.
    logic [2*LaneWidth-1:0]    s3_data, s3_data_d;
    logic [1:0]                s3_ovf, s3_ovf_d;
    logic [1:0]                s3_unf, s3_unf_d;
    logic signed [ExpCalcWidth-1:0] e_calc [2];
    logic [MagWidth-1:0]       norm [2];
    logic [1:0]                res_sign;
    logic [expWidth-1:0]       res_exp [2];
    logic [sigWidth-1:0]       res_frac [2];

    // Split lanes, take absolute value; the most negative sum saturates to all ones.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lane_sum[i]  = bus.in_sum[SumWidth*i +: SumWidth];
            lane_neg[i]  = -lane_sum[i];
            s1_sign_d[i] = lane_sum[i][SumWidth-1];
            if (!lane_sum[i][SumWidth-1]) begin
                s1_mag_d[i] = MagWidth'(lane_sum[i]);
            end else if (lane_sum[i] == {1'b1, {(SumWidth-1){1'b0}}}) begin
                s1_mag_d[i] = '1;
            end else begin
                s1_mag_d[i] = MagWidth'(lane_neg[i]);
            end
        end
    end

    // Priority encode the most-significant one of each magnitude.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            s2_pos_d[i]  = '0;
            s2_zero_d[i] = (s1_mag[i] == '0);
            for (int b = 0; b < MagWidth; b++) begin
                if (s1_mag[i][b]) s2_pos_d[i] = PosWidth'(b);
            end
        end
    end

    // Normalise: shift leading one to bit sigWidth, adjust exponent, saturate or flush.
    always_comb begin
        s3_data_d = '0;
        s3_ovf_d  = '0;
        s3_unf_d  = '0;
        for (int i = 0; i < 2; i++) begin
            e_calc[i] = $signed({{(ExpCalcWidth-expWidth){1'b0}}, s2_exp})
                      + $signed({{(ExpCalcWidth-PosWidth){1'b0}}, s2_pos[i]})
                      - $signed(ExpCalcWidth'(sigWidth));
            if (s2_pos[i] == PosWidth'(MagWidth - 1)) begin
                norm[i] = s2_mag[i] >> 1;  // carry-out: truncate toward zero
            end else begin
                norm[i] = s2_mag[i] << (PosWidth'(sigWidth) - s2_pos[i]);
            end
            res_sign[i] = s2_sign[i];
            res_exp[i]  = e_calc[i][expWidth-1:0];
            res_frac[i] = sigWidth'(norm[i]);
            if (s2_zero[i]) begin
                res_sign[i] = 1'b0;
                res_exp[i]  = '0;
                res_frac[i] = '0;
            end else if (e_calc[i] <= ExpZero) begin
                res_sign[i] = 1'b0;
                res_exp[i]  = '0;
                res_frac[i] = '0;
                s3_unf_d[i] = 1'b1;
            end else if (e_calc[i] > ExpMax) begin
                res_exp[i]  = '1;
                res_frac[i] = '1;
                s3_ovf_d[i] = 1'b1;
            end
            s3_data_d[LaneWidth*i +: LaneWidth] = {res_sign[i], res_exp[i], res_frac[i]};
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_sign  <= '0;
            s1_mag   <= '0;
            s1_exp   <= '0;
        end else if (s1_en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign <= s1_sign_d;
                s1_mag  <= s1_mag_d;
                s1_exp  <= bus.max_exp;
            end
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_sign  <= '0;
            s2_mag   <= '0;
            s2_pos   <= '0;
            s2_zero  <= '0;
            s2_exp   <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_mag  <= s1_mag;
                s2_pos  <= s2_pos_d;
                s2_zero <= s2_zero_d;
                s2_exp  <= s1_exp;
            end
        end
    end

    // Stage 3 (output) register; holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s3_valid <= 1'b0;
            s3_data  <= '0;
            s3_ovf   <= '0;
            s3_unf   <= '0;
        end else if (s3_en) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_data <= s3_data_d;
                s3_ovf  <= s3_ovf_d;
                s3_unf  <= s3_unf_d;
            end
        end
    end

    assign bus.in_ready  = s1_en;
    assign bus.out_valid = s3_valid;
    assign bus.out_data  = s3_data;
    assign bus.out_ovf   = s3_ovf;
    assign bus.out_unf   = s3_unf;
endmodule

// File: tb/tb_exp_normalize_2.sv
// Directed and randomised self-checking bench for exp_normalize_2 (default parameters).
module tb_exp_normalize_2;
    localparam int unsigned ExpW = 4;
    localparam int unsigned SigW = 10;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   errors = 0;
    int   checks = 0;

    exp_normalize_2_if #(.expWidth(ExpW), .sigWidth(SigW)) bus ();

    exp_normalize_2 #(.expWidth(ExpW), .sigWidth(SigW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One lane: returns {ovf, unf, sign, exp[3:0], frac[9:0]}.
    function automatic logic [16:0] model(input logic [3:0] me, input logic [12:0] s);
        int v, mag, p, e, fr;
        logic sg;
        v   = $signed(s);
        sg  = s[12];
        mag = (v < 0) ? -v : v;
        if (mag > 4095) mag = 4095;
        if (mag == 0) return 17'h0;
        p  = $clog2(mag + 1) - 1;
        e  = int'(me) + p - 10;
        fr = ((mag * 1024) >> p) - 1024;
        if (e <= 0) return {1'b0, 1'b1, 15'h0};
        if (e > 15) return {1'b1, 1'b0, sg, 4'hF, 10'h3FF};
        return {2'b00, sg, e[3:0], fr[9:0]};
    endfunction

    // Both lanes: returns {ovf[1:0], unf[1:0], data[29:0]}.
    function automatic logic [33:0] model_pair(input logic [3:0] me, input logic [25:0] s);
        logic [16:0] l0, l1;
        l0 = model(me, s[12:0]);
        l1 = model(me, s[25:13]);
        return {l1[16], l0[16], l1[15], l0[15], l1[14:0], l0[14:0]};
    endfunction

    // Push one pair through an otherwise empty pipeline and check timing and result.
    task automatic send_one(input string tag, input logic [3:0] me, input logic [12:0] s0,
                            input logic [12:0] s1, input logic [29:0] exp_d,
                            input logic [1:0] exp_o, input logic [1:0] exp_u);
        bus.max_exp   = me;
        bus.in_sum    = {s1, s0};
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        bus.in_sum   = '0;
        check({tag, " valid_e1"}, 64'(bus.out_valid), 64'd0);
        step();
        check({tag, " valid_e2"}, 64'(bus.out_valid), 64'd0);
        step();
        check({tag, " valid_e3"}, 64'(bus.out_valid), 64'd1);
        check({tag, " data"}, 64'(bus.out_data), 64'(exp_d));
        check({tag, " ovf"}, 64'(bus.out_ovf), 64'(exp_o));
        check({tag, " unf"}, 64'(bus.out_unf), 64'(exp_u));
        step();
        check({tag, " drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    logic [3:0]  bp_me [5];
    logic [25:0] bp_s  [5];
    logic [33:0] q [$];
    logic [3:0]  r_me;
    logic [25:0] r_s;
    logic        took;
    logic        started;
    int          acc, outs, ins, gaps;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.max_exp   = '0;
        bus.out_ready = 1'b1;
        rstn          = 1'b0;
        #12;
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_data", 64'(bus.out_data), 64'd0);
        check("reset out_ovf", 64'(bus.out_ovf), 64'd0);
        check("reset out_unf", 64'(bus.out_unf), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        step();

        // Hand-computed vectors.
        send_one("normal", 4'd7, 13'h0400, 13'h1C00, {15'h5C00, 15'h1C00}, 2'b00, 2'b00);
        send_one("carry", 4'd7, 13'h0C00, 13'h1000, {15'h63FF, 15'h2200}, 2'b00, 2'b00);
        send_one("ovf", 4'd15, 13'h0800, 13'h1000, {15'h7FFF, 15'h3FFF}, 2'b11, 2'b00);
        send_one("cancel", 4'd12, 13'h0001, 13'h1FFF, {15'h4800, 15'h0800}, 2'b00, 2'b00);
        send_one("unf_zero", 4'd5, 13'h0001, 13'h0000, {15'h0000, 15'h0000}, 2'b00, 2'b01);
        send_one("mixed", 4'd15, 13'h0800, 13'h0001, {15'h1400, 15'h3FFF}, 2'b01, 2'b00);
        send_one("frac", 4'd9, 13'h0ABC, 13'h1F37, {15'h5A48, 15'h295E}, 2'b00, 2'b00);

        // Backpressure: five distinct pairs offered with the consumer stalled.
        bp_me[0] = 4'd7;  bp_s[0] = {13'h0400, 13'h0C00};
        bp_me[1] = 4'd9;  bp_s[1] = {13'h1FFF, 13'h0ABC};
        bp_me[2] = 4'd12; bp_s[2] = {13'h1000, 13'h0001};
        bp_me[3] = 4'd3;  bp_s[3] = {13'h0800, 13'h0100};
        bp_me[4] = 4'd6;  bp_s[4] = {13'h0010, 13'h1F00};
        bus.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            if (acc < 5) begin
                bus.in_valid = 1'b1;
                bus.max_exp  = bp_me[acc];
                bus.in_sum   = bp_s[acc];
            end
            took = bus.in_valid && bus.in_ready;
            step();
            if (took) acc++;
        end
        check("bp accepted", 64'(acc), 64'd3);
        check("bp in_ready", 64'(bus.in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            check("bp stall valid", 64'(bus.out_valid), 64'd1);
            check("bp stall data", 64'({bus.out_ovf, bus.out_unf, bus.out_data}),
                  64'(model_pair(bp_me[0], bp_s[0])));
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("bp drain valid", 64'(bus.out_valid), 64'd1);
            check("bp drain data", 64'({bus.out_ovf, bus.out_unf, bus.out_data}),
                  64'(model_pair(bp_me[k], bp_s[k])));
            step();
        end
        check("bp empty", 64'(bus.out_valid), 64'd0);

        // Streaming: 20 random pairs back to back against the model.
        outs = 0; ins = 0; gaps = 0; started = 1'b0;
        for (int c = 0; c < 60 && outs < 20; c++) begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("stream underflow", 64'(q.size()), 64'd1);
                end else begin
                    check("stream data", 64'({bus.out_ovf, bus.out_unf, bus.out_data}),
                          64'(q.pop_front()));
                end
                outs++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            if (ins < 20) begin
                r_me = 4'($urandom_range(0, 15));
                r_s[12:0]  = 13'($urandom);
                r_s[25:13] = 13'($urandom) >> $urandom_range(0, 12);
                bus.in_valid = 1'b1;
                bus.max_exp  = r_me;
                bus.in_sum   = r_s;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model_pair(r_me, r_s));
                ins++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        check("stream ins", 64'(ins), 64'd20);
        check("stream outs", 64'(outs), 64'd20);
        check("stream gaps", 64'(gaps), 64'd0);

        // Reset with two pairs in flight.
        bus.out_ready = 1'b0;
        bus.max_exp   = 4'd7;
        bus.in_valid  = 1'b1;
        bus.in_sum    = {13'h0400, 13'h0400};
        step();
        bus.in_sum    = {13'h0C00, 13'h0C00};
        step();
        bus.in_valid  = 1'b0;
        step();
        check("rst pre valid", 64'(bus.out_valid), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst out_data", 64'(bus.out_data), 64'd0);
        check("rst in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 rstn = 1'b1;
        send_one("post_rst", 4'd12, 13'h0001, 13'h1FFF, {15'h4800, 15'h0800}, 2'b00, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
